hall_velocity_estimator: RTL

//  Measures motor speed from the three BLDC hall inputs. Each hall state change marks a commutation step.
//  The block counts clk cycles between steps and divides VEL_NUM by that period, one bit per cycle.
//  It emits raw_velocity with a one-cycle velocity_valid strobe; this strobe is the source of the

---
 rtl/bldc_pkg.sv | 40 ++++
 rtl/hall_velocity_estimator_if.sv | 24 ++
 rtl/serial_divider.sv | 89 ++++++++
 rtl/hall_velocity_estimator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Purpose : shared hall-sensor constants, forward-successor helper and state enums.
// Latency : n/a (types and pure functions only).
// Backpres: n/a.
package bldc_pkg;

  // Legal hall codes {C,B,A}, listed in forward commutation order.
  localparam logic [2:0] HALL_A    = 3'b001;
  localparam logic [2:0] HALL_AB   = 3'b011;
  localparam logic [2:0] HALL_B    = 3'b010;
  localparam logic [2:0] HALL_BC   = 3'b110;
  localparam logic [2:0] HALL_C    = 3'b100;
  localparam logic [2:0] HALL_CA   = 3'b101;
  // Codes a healthy sensor set never produces.
  localparam logic [2:0] HALL_NONE = 3'b000;
  localparam logic [2:0] HALL_ALL  = 3'b111;

  typedef enum logic {DIR_REV = 1'b0, DIR_FWD = 1'b1} dir_t;
  typedef enum logic {UNARMED, RUN} est_state_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  // Next state in the forward sequence; illegal codes map to HALL_NONE.
  function automatic logic [2:0] hall_fwd_next(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      HALL_A:  n = HALL_AB;
      HALL_AB: n = HALL_B;
      HALL_B:  n = HALL_BC;
      HALL_BC: n = HALL_C;
      HALL_C:  n = HALL_CA;
      HALL_CA: n = HALL_A;
      default: n = HALL_NONE;
    endcase
    return n;
  endfunction

  function automatic logic hall_legal(input logic [2:0] s);
    return (s != HALL_NONE) && (s != HALL_ALL);
  endfunction

endpackage

// File: rtl/hall_velocity_estimator_if.sv
// Purpose : bundles hall pins and velocity results between the pins/filter side and the estimator.
// Latency : n/a (wiring only).
// Backpres: none; results are strobed, the consumer must take them on velocity_valid.
// Ports   : hall (to estimator), raw_velocity/velocity_valid/direction/hall_fault/overrun (from it).
interface hall_velocity_estimator_if #(
  parameter int OUT_WIDTH = 16
);
  logic [2:0]           hall;
  logic [OUT_WIDTH-1:0] raw_velocity;
  logic                 velocity_valid;
  logic                 direction;
  logic                 hall_fault;
  logic                 overrun;

  modport master (
    output hall,
    input  raw_velocity, velocity_valid, direction, hall_fault, overrun
  );

  modport slave (
    input  hall,
    output raw_velocity, velocity_valid, direction, hall_fault, overrun
  );
endinterface

// File: rtl/serial_divider.sv
// Purpose : restoring unsigned divider, one quotient bit per cycle, abortable.
// Latency : start -> BUSY for NUM_WIDTH cycles -> DONE for one cycle (quotient valid in DONE).
// Backpres: start is accepted only in IDLE or DONE; o_busy covers BUSY and DONE.
// Ports   : i_clk, i_rst_n, i_start, i_dividend, i_divisor, i_abort / o_busy, o_done, o_quotient.
module serial_divider
  import bldc_pkg::*;
#(
  parameter int NUM_WIDTH    = 32,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [NUM_WIDTH-1:0]    i_dividend,
  input  logic [PERIOD_WIDTH-1:0] i_divisor,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NUM_WIDTH-1:0]    o_quotient
);
  localparam int CW = $clog2(NUM_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NUM_WIDTH - 1);

  div_state_t              r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [NUM_WIDTH-1:0]    r_quo;   // dividend bits shift out the top, quotient bits shift in
  logic [PERIOD_WIDTH-1:0] r_rem;
  logic [PERIOD_WIDTH-1:0] r_div;
  logic [PERIOD_WIDTH:0]   w_rem_sh;
  logic [PERIOD_WIDTH:0]   w_diff;
  logic                    w_ge;
  logic                    w_load;

  // Remainder is always < divisor, so the shifted value fits PERIOD_WIDTH+1 bits and the
  // top bit of the difference is a clean borrow flag.
  assign w_rem_sh = {r_rem, r_quo[NUM_WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_ge     = ~w_diff[PERIOD_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (i_abort) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (i_start) begin
          w_state_nxt = BUSY;
          w_load      = 1'b1;
        end
        BUSY: if (r_cnt == LAST) w_state_nxt = DONE;
        DONE: if (i_start) begin
          w_state_nxt = BUSY;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_quo <= i_dividend;
        r_rem <= '0;
        r_div <= i_divisor;
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_quo <= {r_quo[NUM_WIDTH-2:0], w_ge};
        r_rem <= w_ge ? w_diff[PERIOD_WIDTH-1:0] : w_rem_sh[PERIOD_WIDTH-1:0];
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_quotient = r_quo;

endmodule

// File: rtl/hall_velocity_estimator.sv
// Purpose : hall step detection, step-period measurement and VEL_NUM/period velocity estimate.
// Latency : pin change -> step strobe 3 cycles; step strobe -> velocity_valid NUM_WIDTH+1 cycles.
// Backpres: none; a step during a division parks in a one-entry slot (latest wins) and pulses overrun.
// Ports   : i_clk, i_reset_n (async, active low), bus (slave: hall in; velocity/status out).
module hall_velocity_estimator
  import bldc_pkg::*;
#(
  parameter int                      PERIOD_WIDTH   = 24,
  parameter int                      NUM_WIDTH      = 32,
  parameter logic [NUM_WIDTH-1:0]    VEL_NUM        = 32'd50000000,
  parameter int                      OUT_WIDTH      = 16,
  parameter logic [PERIOD_WIDTH-1:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  hall_velocity_estimator_if.slave bus
);
  localparam logic [PERIOD_WIDTH-1:0] TMO_LAST = TIMEOUT_CYCLES - PERIOD_WIDTH'(1);

  logic [2:0]              r_sync1, r_sync2, r_prev;
  logic                    r_step, r_fault, r_ovr;
  dir_t                    r_dir;
  est_state_t              r_est, w_est_nxt;
  logic [PERIOD_WIDTH-1:0] r_cnt, w_cnt_nxt, w_period;
  logic                    r_pend_vld, w_pend_vld_nxt;
  logic [PERIOD_WIDTH-1:0] r_pend, w_pend_nxt;
  logic                    w_div_start, w_div_busy, w_div_done;
  logic [PERIOD_WIDTH-1:0] w_div_divisor;
  logic [NUM_WIDTH-1:0]    w_quo;
  logic [OUT_WIDTH-1:0]    r_vel, w_sat, w_raw;
  logic                    w_change, w_both_legal, w_fwd, w_rev, w_fault;
  logic                    w_tmo, w_run_step;

  // A change is only a step when both ends are legal and adjacent. Leaving a legal state for an
  // illegal or non-adjacent one is a fault; leaving an illegal state just re-seeds r_prev.
  assign w_change     = (r_sync2 != r_prev);
  assign w_both_legal = hall_legal(r_sync2) && hall_legal(r_prev);
  assign w_fwd        = w_change && w_both_legal && (r_sync2 == hall_fwd_next(r_prev));
  assign w_rev        = w_change && w_both_legal && (r_prev == hall_fwd_next(r_sync2));
  assign w_fault      = w_change && hall_legal(r_prev) && !(w_fwd || w_rev);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_step  <= 1'b0;
      r_fault <= 1'b0;
      r_dir   <= DIR_REV;
    end else begin
      r_sync1 <= bus.hall;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_step  <= w_fwd || w_rev;
      r_fault <= w_fault;
      if (w_fwd || w_rev) r_dir <= w_fwd ? DIR_FWD : DIR_REV;
    end
  end

  // Counter holds cycles since the last strobe minus one, so period = counter + 1.
  assign w_period   = (&r_cnt) ? r_cnt : r_cnt + PERIOD_WIDTH'(1);
  assign w_run_step = r_step && (r_est == RUN);

  always_comb begin
    w_est_nxt = r_est;
    w_cnt_nxt = r_cnt;
    w_tmo     = 1'b0;
    unique case (r_est)
      UNARMED: begin
        w_cnt_nxt = '0;
        if (r_step) w_est_nxt = RUN;
      end
      RUN: begin
        if (r_step) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo     = 1'b1;
          w_est_nxt = UNARMED;
          w_cnt_nxt = '0;
        end else if (!(&r_cnt)) begin
          w_cnt_nxt = r_cnt + PERIOD_WIDTH'(1);
        end
      end
      default: w_est_nxt = UNARMED;
    endcase
  end

  // Divider feed: a free divider takes the step directly (or the parked period); in its DONE cycle
  // it chains straight into the parked period, and any step arriving while busy is parked.
  always_comb begin
    w_div_start    = 1'b0;
    w_div_divisor  = w_period;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_nxt     = r_pend;
    if (w_tmo) begin
      w_pend_vld_nxt = 1'b0;
    end else if (!w_div_busy) begin
      if (w_run_step) begin
        w_div_start    = 1'b1;
        w_pend_vld_nxt = 1'b0;
      end else if (r_pend_vld) begin
        w_div_start    = 1'b1;
        w_div_divisor  = r_pend;
        w_pend_vld_nxt = 1'b0;
      end
    end else begin
      if (w_div_done && r_pend_vld) begin
        w_div_start    = 1'b1;
        w_div_divisor  = r_pend;
        w_pend_vld_nxt = 1'b0;
      end
      if (w_run_step) begin
        w_pend_vld_nxt = 1'b1;
        w_pend_nxt     = w_period;
      end
    end
  end

  serial_divider #(
    .NUM_WIDTH    (NUM_WIDTH),
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_reset_n),
    .i_start    (w_div_start),
    .i_dividend (VEL_NUM),
    .i_divisor  (w_div_divisor),
    .i_abort    (w_tmo),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  assign w_sat = (|w_quo[NUM_WIDTH-1:OUT_WIDTH]) ? '1 : w_quo[OUT_WIDTH-1:0];
  // Results appear in the strobe cycle itself; r_vel keeps the value between strobes.
  assign w_raw = w_tmo ? '0 : (w_div_done ? w_sat : r_vel);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_est      <= UNARMED;
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_vel      <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_est      <= w_est_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend     <= w_pend_nxt;
      r_vel      <= w_raw;
      r_ovr      <= w_run_step && w_div_busy;
    end
  end

  assign bus.raw_velocity   = w_raw;
  assign bus.velocity_valid = w_tmo || w_div_done;
  assign bus.direction      = r_dir;
  assign bus.hall_fault     = r_fault;
  assign bus.overrun        = r_ovr;

endmodule
